// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared parameters, types and helpers for the register file
package regfile_pkg;

    localparam int XLEN_DEFAULT  = 32;
    localparam int NREGS_DEFAULT = 32;

    // Address width for an n-entry register file; never narrower than one bit.
    function automatic int addr_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [XLEN_DEFAULT-1:0] data_t;
    typedef logic [4:0]              reg_addr_t;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// rtl/regfile_sb_scoreboard.sv - pending-write busy bits with reservation handshake
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   rsv_valid/rsv_addr  reservation request for a destination register
//   rsv_ready           reservation accepted this cycle (combinational)
//   we/waddr            architectural write; clears the written register's busy bit
//   flush               clears every busy bit at the edge, drops that cycle's reservation
//   busy                per-register busy vector (bit 0 is always 0)
module regfile_sb_scoreboard
    import regfile_pkg::*;
#(
    parameter int NREGS = NREGS_DEFAULT,
    localparam int AW   = addr_w(NREGS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             rsv_valid,
    input  logic [AW-1:0]    rsv_addr,
    output logic             rsv_ready,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic             flush,
    output logic [NREGS-1:0] busy
);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             rsv_fire;

    // A write landing this cycle frees the register, so a reservation of the
    // same register can be accepted immediately.
    assign rsv_ready = (rsv_addr == '0) || !busy_q[rsv_addr]
                     || (we && (waddr == rsv_addr));
    assign rsv_fire  = rsv_valid && rsv_ready;

    // Priority per register: flush > reservation > write-clear. The
    // reservation is applied after the write-clear so it wins on collision.
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end else begin
            if (we && (waddr != '0)) begin
                busy_d[waddr] = 1'b0;
            end
            if (rsv_fire && (rsv_addr != '0)) begin
                busy_d[rsv_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with N read ports, one write port and busy scoreboard
//
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   we/waddr/wdata         clocked write port (writes to x0 ignored)
//   ra/rd/rbusy            NRD packed combinational read ports, port 0 in LSBs
//   rsv_valid/rsv_addr     destination reservation request
//   rsv_ready              reservation accepted this cycle
//   flush                  synchronous clear of all busy bits, data retained
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int NREGS  = NREGS_DEFAULT,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = addr_w(NREGS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [NRD*AW-1:0] ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]    rbusy,
    input  logic              rsv_valid,
    input  logic [AW-1:0]     rsv_addr,
    output logic              rsv_ready,
    input  logic              flush
);

    localparam bit BYP = (BYPASS != 0);

    logic [XLEN-1:0]  mem [NREGS];
    logic [NREGS-1:0] valid;
    logic [NREGS-1:0] busy;
    logic             wr_en;

    assign wr_en = we && (waddr != '0);

    // The data array has no reset; the valid vector masks stale contents.
    always_ff @(posedge clk) begin
        if (reset_n && wr_en) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[waddr] <= 1'b1;
        end
    end

    regfile_sb_scoreboard #(
        .NREGS (NREGS)
    ) u_scoreboard (
        .clk       (clk),
        .reset_n   (reset_n),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .rsv_ready (rsv_ready),
        .we        (we),
        .waddr     (waddr),
        .flush     (flush),
        .busy      (busy)
    );

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic            hit;
        logic [XLEN-1:0] rdata;

        assign addr = ra[i*AW +: AW];
        // Forwarding is suppressed during reset so rd reads as zero throughout.
        assign hit  = BYP && reset_n && wr_en && (waddr == addr);

        always_comb begin
            rdata = '0;
            if (hit) begin
                rdata = wdata;
            end else if ((addr != '0) && valid[addr]) begin
                rdata = mem[addr];
            end
        end

        assign rd[i*XLEN +: XLEN] = rdata;
        assign rbusy[i] = !hit && (addr != '0) && busy[addr];
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed self-checking bench for regfile_sb
module tb_regfile_sb;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic [2*AW-1:0] ra;
    logic          rsv_valid;
    logic [AW-1:0] rsv_addr;
    logic          flush;

    logic [63:0]   rd, rd_nb;
    logic [1:0]    rbusy, rbusy_nb;
    logic          rsv_ready, rsv_ready_nb;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(1)) dut (
        .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
        .ra(ra), .rd(rd), .rbusy(rbusy), .rsv_valid(rsv_valid),
        .rsv_addr(rsv_addr), .rsv_ready(rsv_ready), .flush(flush)
    );

    regfile_sb #(.XLEN(32), .NREGS(32), .NRD(2), .BYPASS(0)) dut_nb (
        .clk(clk), .reset_n(reset_n), .we(we), .waddr(waddr), .wdata(wdata),
        .ra(ra), .rd(rd_nb), .rbusy(rbusy_nb), .rsv_valid(rsv_valid),
        .rsv_addr(rsv_addr), .rsv_ready(rsv_ready_nb), .flush(flush)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        ra = {a1, a0};
        #1;
    endtask

    task automatic idle();
        we = 1'b0; rsv_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic reserve(input logic [AW-1:0] a);
        rsv_valid = 1'b1; rsv_addr = a;
        tick();
        rsv_valid = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; ra = '0;
        rsv_valid = 1'b0; rsv_addr = '0; flush = 1'b0;
        tick();
        tick();
        chk("reset_low_rd0", rd[31:0], 32'h0);
        #2 reset_n = 1'b1;

        // Reset then read
        rsv_addr = 5'd5;
        set_ra(5'd5, 5'd0);
        chk("rst_rd0", rd[31:0], 32'h0);
        chk("rst_rd1", rd[63:32], 32'h0);
        chk("rst_rbusy", {30'b0, rbusy}, 32'h0);
        chk("rst_rsv_ready", {31'b0, rsv_ready}, 32'h1);

        // Write/read, bypass vs no bypass
        tick();
        we = 1'b1; waddr = 5'd3; wdata = 32'hDEADBEEF;
        set_ra(5'd3, 5'd0);
        chk("byp_same_cycle", rd[31:0], 32'hDEADBEEF);
        chk("nobyp_same_cycle", rd_nb[31:0], 32'h0);
        tick();
        idle();
        #1;
        chk("byp_next_cycle", rd[31:0], 32'hDEADBEEF);
        chk("nobyp_next_cycle", rd_nb[31:0], 32'hDEADBEEF);
        tick();
        chk("byp_later_cycle", rd[31:0], 32'hDEADBEEF);

        // x0 protection
        we = 1'b1; waddr = 5'd0; wdata = 32'h1234;
        set_ra(5'd0, 5'd3);
        chk("x0_write_same", rd[31:0], 32'h0);
        tick();
        idle();
        #1;
        chk("x0_read", rd[31:0], 32'h0);
        rsv_valid = 1'b1; rsv_addr = 5'd0;
        #1;
        chk("x0_rsv_ready", {31'b0, rsv_ready}, 32'h1);
        tick();
        idle();
        #1;
        chk("x0_rbusy", {31'b0, rbusy[0]}, 32'h0);

        // Scoreboard on register 7
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        set_ra(5'd7, 5'd0);
        chk("r7_rsv_ready_first", {31'b0, rsv_ready}, 32'h1);
        tick();
        #1;
        chk("r7_busy", {31'b0, rbusy[0]}, 32'h1);
        chk("r7_second_rsv_ready", {31'b0, rsv_ready}, 32'h0);
        rsv_valid = 1'b0;
        we = 1'b1; waddr = 5'd7; wdata = 32'h55;
        #1;
        chk("r7_write_rsv_ready", {31'b0, rsv_ready}, 32'h1);
        chk("r7_byp_rbusy", {31'b0, rbusy[0]}, 32'h0);
        tick();
        idle();
        #1;
        chk("r7_after_write_rbusy", {31'b0, rbusy[0]}, 32'h0);
        chk("r7_after_write_rd", rd[31:0], 32'h55);

        // Same-cycle write and reservation: reservation wins
        we = 1'b1; waddr = 5'd7; wdata = 32'h77;
        rsv_valid = 1'b1; rsv_addr = 5'd7;
        tick();
        idle();
        #1;
        chk("r7_wr_rsv_rd", rd[31:0], 32'h77);
        chk("r7_wr_rsv_rbusy", {31'b0, rbusy[0]}, 32'h1);
        chk("r7_wr_rsv_rd_nb", rd_nb[31:0], 32'h77);

        // Flush
        write_reg(5'd2, 32'h22);
        write_reg(5'd4, 32'h44);
        write_reg(5'd9, 32'h99);
        reserve(5'd2);
        reserve(5'd4);
        reserve(5'd9);
        set_ra(5'd9, 5'd4);
        chk("pre_flush_r9_busy", {31'b0, rbusy[0]}, 32'h1);
        chk("pre_flush_r4_busy", {31'b0, rbusy[1]}, 32'h1);
        flush = 1'b1; rsv_valid = 1'b1; rsv_addr = 5'd11;
        tick();
        idle();
        set_ra(5'd2, 5'd4);
        chk("flush_r2_r4_rbusy", {30'b0, rbusy}, 32'h0);
        chk("flush_r2_rd", rd[31:0], 32'h22);
        chk("flush_r4_rd", rd[63:32], 32'h44);
        set_ra(5'd9, 5'd11);
        chk("flush_r9_r11_rbusy", {30'b0, rbusy}, 32'h0);
        chk("flush_r9_rd", rd[31:0], 32'h99);
        set_ra(5'd7, 5'd0);
        chk("flush_r7_rbusy", {31'b0, rbusy[0]}, 32'h0);

        // Async reset mid-operation
        reserve(5'd6);
        write_reg(5'd8, 32'hAA);
        set_ra(5'd8, 5'd6);
        chk("pre_rst_r8_rd", rd[31:0], 32'hAA);
        chk("pre_rst_r6_rbusy", {31'b0, rbusy[1]}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_r8_rd", rd[31:0], 32'h0);
        chk("async_rst_r6_rbusy", {31'b0, rbusy[1]}, 32'h0);
        #1 reset_n = 1'b1;
        rsv_addr = 5'd6;
        #1;
        chk("post_rst_r6_rsv_ready", {31'b0, rsv_ready}, 32'h1);
        tick();
        chk("post_rst_r8_rd", rd[31:0], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with an integrated pending-write scoreboard for the multi-cycle RISC-V core. Provides N combinational read ports and one clocked write port. Tracks a per-register busy bit so the controller can stall on operands whose writeback has not landed. Reset clears architectural state through a valid-bit vector rather than a full array reset.

## Interface
Parameters:
- XLEN, 32, data width in bits
- NREGS, 32, number of registers (power of two, ≥ 2); register 0 hardwired to zero
- NRD, 2, number of read ports (1–4)
- BYPASS, 1, 1 = same-cycle write-to-read forwarding, 0 = none

Ports (AW = $clog2(NREGS)):
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- we  in  1  write enable
- waddr  in  AW  write address
- wdata  in  XLEN  write data
- ra  in  NRD×AW  read addresses, packed, port 0 in LSBs
- rd  out  NRD×XLEN  read data, packed
- rbusy  out  NRD  per-port busy flag for ra[i]
- rsv_valid  in  1  request to mark a destination pending
- rsv_addr  in  AW  destination register to reserve
- rsv_ready  out  1  reservation accepted this cycle
- flush  in  1  synchronous clear of all busy bits; data retained

## Operation
- Storage: XLEN×NREGS array (no reset), plus valid[NREGS] and busy[NREGS] vectors (async reset to 0).
- Read, port i: rd[i] = 0 if ra[i]==0 or !valid[ra[i]]; else array[ra[i]].
- BYPASS=1: if we && waddr==ra[i] && waddr!=0, rd[i] = wdata and rbusy[i] = 0.
- rbusy[i] = busy[ra[i]], except for the bypass case above. Always 0 for ra[i]==0.
- Write: on clk rising edge with we && waddr!=0: array[waddr] ← wdata, valid[waddr] ← 1, busy[waddr] ← 0. A write to register 0 is ignored.
- Reservation: rsv_ready = !busy[rsv_addr] || (we && waddr==rsv_addr), held combinational. rsv_addr==0 → rsv_ready=1 and no state change. Handshake completes when rsv_valid && rsv_ready, and then busy[rsv_addr] ← 1 at the edge.
- Same-cycle write and reservation to the same register: data is written, and busy ends at 1 because the reservation wins.
- flush: all busy bits ← 0 at the edge. Any reservation that cycle is discarded. A write that cycle still lands.
- Priority for the busy bit, per register: flush > reservation > write-clear.

## Timing
- Read ports: zero latency, combinational from ra, we, waddr, wdata.
- Write visible on rd the cycle after the edge. With BYPASS=1 it is visible in the same cycle.
- busy set/clear takes effect the cycle after the edge.
- Reset: reset_n low asynchronously forces valid=0 and busy=0. While low, and after release: rd=0, rbusy=0, rsv_ready=1 for all addresses until written.
- Reset mid-operation: all pending reservations are dropped. Array contents are undefined but masked by valid=0.
- Edges with reset_n low perform no write and no reservation.

## Structure
- Package regfile_pkg:
  - XLEN_DEFAULT, NREGS_DEFAULT
  - localparam-style function addr_w(n)
  - typedefs data_t (logic[XLEN-1:0]) and reg_addr_t (logic[4:0]) for the default configuration
- Sub-module regfile_sb_scoreboard: owns busy[]. Inputs: reservation handshake, write-clear, flush. Outputs: busy vector and rsv_ready.
- Top: owns array, valid[], read muxing and bypass. Read ports are built with a generate loop over NRD.

## Test plan
- Reset then read: reset_n=0→1, read ra0=5, ra1=0 → rd=0,0; rbusy=0; rsv_ready=1.
- Write/read with BYPASS=1: we=1, waddr=3, wdata=0xDEADBEEF, ra0=3 → rd0=0xDEADBEEF in the same cycle and every later cycle. With BYPASS=0, the same stimulus gives rd0=0 in the same cycle and 0xDEADBEEF the next cycle.
- x0 protection: write 0x1234 to register 0, then read register 0 → rd=0. Reserve register 0 → rsv_ready=1, rbusy=0.
- Scoreboard:
  - Reserve register 7 → next cycle rbusy=1 for ra=7.
  - A second reserve of register 7 → rsv_ready=0.
  - Write register 7 with 0x55 → rbusy=0 the next cycle, rd=0x55.
  - Same-cycle write and reserve of register 7 → rd=new data, rbusy=1.
- Flush: reserve registers 2, 4, 9 on successive cycles, then flush=1 together with rsv_valid for register 11 → next cycle all rbusy=0 and register 11 is not busy. Data previously written to registers 2, 4, 9 is unchanged.
- Async reset mid-operation: reserve register 6, write 0xAA to register 8, then pulse reset_n low between clock edges → rd for register 8 drops to 0 immediately and rbusy for register 6 drops to 0 immediately. After release, rsv_ready=1 for register 6.
